// File: rtl/msrv32_imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the default NOP word and the wait-counter width.
package msrv32_imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD   = 32'h00000013;
  localparam int          WAIT_CNT_W = 4;

  // Word index relative to the boot address; addresses below it wrap high.
  function automatic logic [29:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/msrv32_imem_array.sv
// Single-port synchronous word RAM. The read register resets to, and can be
// loaded with, a fill word instead of array contents.
module msrv32_imem_array
  import msrv32_imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10,
  parameter logic [31:0] FILL_WORD   = NOP_WORD
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          rd_nop,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Array write; contents are never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; an errored read skips the array entirely.
  always_ff @(posedge clock) begin
    if (rst) begin
      rdata_r <= FILL_WORD;
    end else if (re) begin
      rdata_r <= rd_nop ? FILL_WORD : mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/msrv32_imem_responder.sv
// Memory side of the fetch interface: accepts one address per handshake,
// answers after WAIT_STATES+1 cycles, and exposes a loader write port.
module msrv32_imem_responder
  import msrv32_imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          WAIT_STATES  = 1,
  parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
  parameter logic [31:0] NOP_INSTR    = NOP_WORD
) (
  input  logic        clock,
  input  logic        rst_in,
  input  logic [31:0] iaddr_in,
  input  logic        ireq_in,
  output logic        iready_out,
  output logic [31:0] instr_out,
  output logic        ivalid_out,
  output logic        ierr_out,
  input  logic        ld_we_in,
  input  logic [31:0] ld_addr_in,
  input  logic [31:0] ld_data_in
);

  localparam int                    AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]           DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
  localparam bit                    NO_WAIT   = (WAIT_STATES == 0);

  imem_state_e           state_r;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [AW-1:0]         idx_r;
  logic                  err_r;
  logic                  ivalid_r;
  logic                  ierr_r;

  logic [29:0]   fetch_idx_s;
  logic [29:0]   ld_idx_s;
  logic          fetch_err_s;
  logic          open_s;
  logic          iready_s;
  logic          accept_s;
  logic          mem_we_s;
  logic          enter_resp_s;
  logic          rd_nop_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   rdata_s;

  // Address decode, handshake and the shared RAM port steering.
  always_comb begin
    fetch_idx_s = word_index(iaddr_in, BOOT_ADDRESS);
    ld_idx_s    = word_index(ld_addr_in, BOOT_ADDRESS);
    fetch_err_s = (iaddr_in[1:0] != 2'b00) || (fetch_idx_s >= DEPTH_IDX);
    open_s      = (state_r == ST_IDLE) || (state_r == ST_RESP);
    iready_s    = !rst_in && open_s && !ld_we_in;
    accept_s    = ireq_in && iready_s;
    mem_we_s    = ld_we_in && open_s && (ld_idx_s < DEPTH_IDX);
    // Loads and reads never collide: loads stall accepts and are dropped in WAIT.
    if (state_r == ST_WAIT) begin
      enter_resp_s = (cnt_r <= WAIT_CNT_W'(1));
      rd_nop_s     = err_r;
      mem_addr_s   = idx_r;
    end else begin
      enter_resp_s = accept_s && NO_WAIT;
      rd_nop_s     = fetch_err_s;
      mem_addr_s   = mem_we_s ? ld_idx_s[AW-1:0] : fetch_idx_s[AW-1:0];
    end
  end

  // Fetch FSM with registered response flags.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      idx_r    <= '0;
      err_r    <= 1'b0;
      ivalid_r <= 1'b0;
      ierr_r   <= 1'b0;
    end else begin
      ivalid_r <= 1'b0;
      ierr_r   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            idx_r    <= fetch_idx_s[AW-1:0];
            err_r    <= fetch_err_s;
            cnt_r    <= WAIT_LOAD;
            state_r  <= enter_resp_s ? ST_RESP : ST_WAIT;
            ivalid_r <= enter_resp_s;
            ierr_r   <= enter_resp_s && fetch_err_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - WAIT_CNT_W'(1);
          if (enter_resp_s) begin
            state_r  <= ST_RESP;
            ivalid_r <= 1'b1;
            ierr_r   <= err_r;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  msrv32_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .FILL_WORD   (NOP_INSTR)
  ) u_array (
    .clock  (clock),
    .rst    (rst_in),
    .we     (mem_we_s),
    .re     (enter_resp_s),
    .rd_nop (rd_nop_s),
    .addr   (mem_addr_s),
    .wdata  (ld_data_in),
    .rdata  (rdata_s)
  );

  assign iready_out = iready_s;
  assign instr_out  = rdata_s;
  assign ivalid_out = ivalid_r;
  assign ierr_out   = ierr_r;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// Self-checking bench: three responders (WAIT_STATES 1, 0, 15) sharing the
// loader and address buses, with a per-instance response scoreboard.
module tb_msrv32_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0  = 32'h00500093;
  localparam logic [31:0] W1  = 32'h00A00113;

  logic        clock = 1'b0;
  logic        rst, ld_we;
  logic [31:0] iaddr, ld_addr, ld_data;
  logic        req_m, req_z, req_l;
  logic        rdy_m, rdy_z, rdy_l;
  logic        vld_m, vld_z, vld_l;
  logic        err_m, err_z, err_l;
  logic [31:0] instr_m, instr_z, instr_l;

  logic [32:0] q_m[$], q_z[$], q_l[$];
  logic [32:0] exp_m, exp_z, exp_l;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  msrv32_imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BOOT_ADDRESS(32'h0), .NOP_INSTR(NOP)) dut_m (
    .clock(clock), .rst_in(rst), .iaddr_in(iaddr), .ireq_in(req_m), .iready_out(rdy_m),
    .instr_out(instr_m), .ivalid_out(vld_m), .ierr_out(err_m),
    .ld_we_in(ld_we), .ld_addr_in(ld_addr), .ld_data_in(ld_data));

  msrv32_imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BOOT_ADDRESS(32'h0), .NOP_INSTR(NOP)) dut_z (
    .clock(clock), .rst_in(rst), .iaddr_in(iaddr), .ireq_in(req_z), .iready_out(rdy_z),
    .instr_out(instr_z), .ivalid_out(vld_z), .ierr_out(err_z),
    .ld_we_in(ld_we), .ld_addr_in(ld_addr), .ld_data_in(ld_data));

  msrv32_imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15), .BOOT_ADDRESS(32'h0), .NOP_INSTR(NOP)) dut_l (
    .clock(clock), .rst_in(rst), .iaddr_in(iaddr), .ireq_in(req_l), .iready_out(rdy_l),
    .instr_out(instr_l), .ivalid_out(vld_l), .ierr_out(err_l),
    .ld_we_in(ld_we), .ld_addr_in(ld_addr), .ld_data_in(ld_data));

  // Scoreboard pop/compare on every valid pulse, per instance.
  always @(negedge clock) begin
    if (vld_m === 1'b1) begin
      checks++;
      if (q_m.size() == 0) begin
        errors++; $display("FAIL resp_m unexpected ivalid err=%b instr=%h", err_m, instr_m);
      end else begin
        exp_m = q_m.pop_front();
        if ({err_m, instr_m} !== exp_m) begin
          errors++; $display("FAIL resp_m got err=%b instr=%h want err=%b instr=%h", err_m, instr_m, exp_m[32], exp_m[31:0]);
        end
      end
    end
    if (vld_z === 1'b1) begin
      checks++;
      if (q_z.size() == 0) begin
        errors++; $display("FAIL resp_z unexpected ivalid err=%b instr=%h", err_z, instr_z);
      end else begin
        exp_z = q_z.pop_front();
        if ({err_z, instr_z} !== exp_z) begin
          errors++; $display("FAIL resp_z got err=%b instr=%h want err=%b instr=%h", err_z, instr_z, exp_z[32], exp_z[31:0]);
        end
      end
    end
    if (vld_l === 1'b1) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++; $display("FAIL resp_l unexpected ivalid err=%b instr=%h", err_l, instr_l);
      end else begin
        exp_l = q_l.pop_front();
        if ({err_l, instr_l} !== exp_l) begin
          errors++; $display("FAIL resp_l got err=%b instr=%h want err=%b instr=%h", err_l, instr_l, exp_l[32], exp_l[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic vld(input int i);
    case (i)
      0: return vld_m;
      1: return vld_z;
      default: return vld_l;
    endcase
  endfunction

  task automatic set_req(input int i, input logic v);
    case (i)
      0: req_m = v;
      1: req_z = v;
      default: req_l = v;
    endcase
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  // Drives one request and returns cycles from accept cycle to ivalid (-1 on timeout).
  task automatic issue(input int i, input logic [31:0] a, output int lat);
    iaddr = a;
    set_req(i, 1'b1);
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) set_req(i, 1'b0);
    end while (!vld(i) && lat < 40);
    if (!vld(i)) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL reset_iready got %b want 0", rdy_m); end
    checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL reset_ivalid got %b want 0", vld_m); end
    checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL reset_ierr got %b want 0", err_m); end
    checks++; if (instr_m !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_m, NOP); end
    checks++; if (instr_z !== NOP || instr_l !== NOP) begin errors++; $display("FAIL reset_instr_zl got %h/%h want %h", instr_z, instr_l, NOP); end
    rst = 1'b0;
    #1;
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL idle_iready got %b want 1", rdy_m); end
  endtask

  task automatic test_load_fetch();
    int lat;
    load(32'h0, W0);
    load(32'h4, W1);
    q_m.push_back({1'b0, W0});
    issue(0, 32'h0, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL fetch_latency got %0d want 2", lat); end
    step();
    checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", vld_m); end
    checks++; if (instr_m !== W0) begin errors++; $display("FAIL instr_hold got %h want %h", instr_m, W0); end
  endtask

  task automatic test_back_to_back();
    int n;
    iaddr = 32'h0; req_m = 1'b1;
    q_m.push_back({1'b0, W0});
    n = 0;
    do begin step(); n++; end while (!vld_m && n < 10);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_first got %0d want 2", n); end
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp got %b want 1", rdy_m); end
    iaddr = 32'h4;
    q_m.push_back({1'b0, W1});
    n = 0;
    do begin step(); n++; end while (!vld_m && n < 10);
    req_m = 1'b0;
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_interval got %0d want 2", n); end
    step();
  endtask

  task automatic test_errors();
    int lat;
    q_m.push_back({1'b1, NOP});
    issue(0, 32'h2, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL misalign_latency got %0d want 2", lat); end
    step();
    checks++; if (vld_m !== 1'b0 || err_m !== 1'b0) begin errors++; $display("FAIL err_clear got vld=%b err=%b want 0/0", vld_m, err_m); end
    checks++; if (instr_m !== NOP) begin errors++; $display("FAIL err_instr_hold got %h want %h", instr_m, NOP); end
    q_m.push_back({1'b1, NOP});
    issue(0, 32'h00001000, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL range_latency got %0d want 2", lat); end
    step();
  endtask

  task automatic test_load_priority();
    int lat;
    iaddr = 32'h8; req_m = 1'b1;
    ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'hCAFE0001;
    #1;
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL ld_priority_ready got %b want 0", rdy_m); end
    step();
    ld_we = 1'b0;
    #1;
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL ld_release_ready got %b want 1", rdy_m); end
    q_m.push_back({1'b0, 32'hCAFE0001});
    issue(0, 32'h8, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ld_priority_latency got %0d want 2", lat); end
    step();
  endtask

  task automatic test_loader_addr();
    int lat;
    load(32'h0000000E, 32'h0ABCDEF3);
    load(32'h00001000, 32'hDEADBEEF);
    q_m.push_back({1'b0, 32'h0ABCDEF3});
    issue(0, 32'hC, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ld_misalign_latency got %0d want 2", lat); end
    q_m.push_back({1'b0, W0});
    issue(0, 32'h0, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ld_range_latency got %0d want 2", lat); end
    step();
  endtask

  task automatic test_wait_states();
    int lat;
    q_z.push_back({1'b0, W1});
    issue(1, 32'h4, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL ws0_latency got %0d want 1", lat); end
    step();
    checks++; if (vld_z !== 1'b0) begin errors++; $display("FAIL ws0_pulse got %b want 0", vld_z); end
    q_l.push_back({1'b0, W0});
    issue(2, 32'h0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL ws15_latency got %0d want 16", lat); end
    step();
  endtask

  task automatic test_reset_in_wait();
    int lat;
    iaddr = 32'h4; req_m = 1'b1;
    step();
    req_m = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL abandon_ivalid cycle %0d got %b want 0", k, vld_m); end
      step();
    end
    checks++; if (instr_m !== NOP) begin errors++; $display("FAIL abandon_instr got %h want %h", instr_m, NOP); end
    q_m.push_back({1'b0, W0});
    issue(0, 32'h0, lat);
    q_m.push_back({1'b0, W1});
    issue(0, 32'h4, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL retain_latency got %0d want 2", lat); end
    step();
  endtask

  task automatic test_write_in_wait();
    int lat;
    load(32'h10, 32'h11111111);
    iaddr = 32'h10; req_m = 1'b1;
    q_m.push_back({1'b0, 32'h11111111});
    step();
    req_m = 1'b0;
    ld_we = 1'b1; ld_addr = 32'h10; ld_data = 32'h22222222;
    #1;
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL wait_ready got %b want 0", rdy_m); end
    step();
    ld_we = 1'b0;
    checks++; if (vld_m !== 1'b1) begin errors++; $display("FAIL wait_resp got %b want 1", vld_m); end
    step();
    q_m.push_back({1'b0, 32'h11111111});
    issue(0, 32'h10, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL dropped_latency got %0d want 2", lat); end
    step();
  endtask

  task automatic test_drain();
    checks++;
    if (q_m.size() != 0 || q_z.size() != 0 || q_l.size() != 0) begin
      errors++; $display("FAIL drain got %0d/%0d/%0d pending want 0/0/0", q_m.size(), q_z.size(), q_l.size());
    end
  endtask

  initial begin
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; iaddr = '0;
    req_m = 1'b0; req_z = 1'b0; req_l = 1'b0;
    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_errors();
    test_load_priority();
    test_loader_addr();
    test_wait_states();
    test_reset_in_wait();
    test_write_in_wait();
    repeat (3) step();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
